// File: rtl/game_pkg.sv
// Shared game types and constants for the player motion and map renderer blocks.
package game_pkg;

    typedef enum logic [1:0] {
        NORTH = 2'd0,
        SOUTH = 2'd1,
        EAST  = 2'd2,
        WEST  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        VOID  = 2'd0,
        GRASS = 2'd1,
        WATER = 2'd2,
        SAND  = 2'd3
    } tile_t;

    localparam int MAP_W      = 100;
    localparam int MAP_H      = 75;
    localparam int TILE_SHIFT = 5;
    localparam int WORLD_W    = 3200;
    localparam int WORLD_H    = 2400;
    localparam int BORDER     = 32;

    // Grass and sand can be walked on; water and void cannot.
    function automatic logic is_passable(input tile_t t);
        return (t == GRASS) || (t == SAND);
    endfunction

endpackage

// File: rtl/tile_index.sv
// Converts a world pixel coordinate into a linear tile map index
// (row * MAP_W + column). Purely combinational; shared with the renderer.
module tile_index
    import game_pkg::*;
(
    input  logic [11:0] x,
    input  logic [11:0] y,
    output logic [12:0] addr
);

    logic [6:0]  x_tile;
    logic [6:0]  y_tile;
    logic [12:0] y_wide;
    logic [12:0] row_base;

    // Row base uses y*100 = y*64 + y*32 + y*4 so no multiplier is needed.
    always_comb begin
        x_tile   = 7'(x >> TILE_SHIFT);
        y_tile   = 7'(y >> TILE_SHIFT);
        y_wide   = {6'd0, y_tile};
        row_base = (y_wide << 6) + (y_wide << 5) + (y_wide << 2);
        addr     = row_base + {6'd0, x_tile};
    end

endmodule

// File: rtl/player_motion.sv
// Per-frame player movement: samples the direction keys at the start of
// vertical sync, computes a clamped candidate position, checks the two
// leading-edge corner tiles through the tile ROM port and commits the move
// only when both are passable.
// Optional build macro SPRINT_EN: adds the sprint input (double step) with a
// single retry at normal speed when the sprint step is blocked.
module player_motion
    import game_pkg::*;
#(
    parameter int SPEED  = 2,
    parameter int HALF   = 15,
    parameter int X_INIT = 1600,
    parameter int Y_INIT = 1200
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        VGA_VS,
    input  logic [3:0]  keys,
`ifdef SPRINT_EN
    input  logic        sprint,
`endif
    output logic        tile_req,
    output logic [12:0] tile_addr,
    input  logic [1:0]  tile_data,
    output logic [11:0] x_pos,
    output logic [11:0] y_pos,
    output logic [1:0]  dir,
    output logic        moving,
    output logic        update_done
);

    localparam logic signed [12:0] X_MIN = 13'(BORDER + HALF);
    localparam logic signed [12:0] X_MAX = 13'(WORLD_W - BORDER - 1 - HALF);
    localparam logic signed [12:0] Y_MIN = 13'(BORDER + HALF);
    localparam logic signed [12:0] Y_MAX = 13'(WORLD_H - BORDER - 1 - HALF);
    localparam logic [11:0]        HALF12 = 12'(HALF);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CALC   = 3'd1,
        REQ0   = 3'd2,
        WAIT0  = 3'd3,
        REQ1   = 3'd4,
        WAIT1  = 3'd5,
        COMMIT = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic        vs_q, vs_d;
    logic        tick_q, tick_d;
    logic [3:0]  keys_q, keys_d;
    logic [11:0] cand_x_q, cand_x_d;
    logic [11:0] cand_y_q, cand_y_d;
    logic        pass_a_q, pass_a_d;
    logic [11:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    dir_t        dir_q, dir_d;
    logic        moving_q, moving_d;
    logic        done_q, done_d;
`ifdef SPRINT_EN
    logic        sprint_q, sprint_d;
    logic        retry_q, retry_d;
`endif

    dir_t              win_dir;
    logic signed [12:0] step_s;
    logic signed [12:0] cx_s;
    logic signed [12:0] cy_s;
    logic [11:0]        cand_x_c;
    logic [11:0]        cand_y_c;
    logic [11:0]        ax, ay, bx, by;
    logic [11:0]        corner_x;
    logic [11:0]        corner_y;
    logic [12:0]        corner_addr;
    logic               tile_ok;

    // Saturate a signed candidate coordinate into the playable range.
    function automatic logic [11:0] clamp_coord(input logic signed [12:0] v,
                                                input logic signed [12:0] lo,
                                                input logic signed [12:0] hi);
        logic signed [12:0] r;
        r = v;
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end
        return r[11:0];
    endfunction

    // Key priority up > down > left > right; keys = {up, down, left, right}.
    function automatic dir_t key_dir(input logic [3:0] k);
        dir_t d;
        if (k[3])      d = NORTH;
        else if (k[2]) d = SOUTH;
        else if (k[1]) d = WEST;
        else           d = EAST;
        return d;
    endfunction

    // Candidate position from latched keys, and corner coordinates from the stored candidate.
    always_comb begin
        win_dir = key_dir(keys_q);
        step_s  = 13'(SPEED);
`ifdef SPRINT_EN
        // The doubled step only applies to the first attempt; a retry from WAIT1 uses SPEED.
        if ((state_q == CALC) && sprint_q) begin
            step_s = 13'(2 * SPEED);
        end
`endif
        cx_s = $signed({1'b0, x_q});
        cy_s = $signed({1'b0, y_q});
        case (win_dir)
            NORTH:   cy_s = cy_s - step_s;
            SOUTH:   cy_s = cy_s + step_s;
            EAST:    cx_s = cx_s + step_s;
            default: cx_s = cx_s - step_s;
        endcase
        cand_x_c = clamp_coord(cx_s, X_MIN, X_MAX);
        cand_y_c = clamp_coord(cy_s, Y_MIN, Y_MAX);

        ax = cand_x_q - HALF12;
        bx = cand_x_q + HALF12;
        ay = cand_y_q - HALF12;
        by = cand_y_q + HALF12;
        case (dir_q)
            NORTH:   begin ay = cand_y_q - HALF12; by = cand_y_q - HALF12; end
            SOUTH:   begin ay = cand_y_q + HALF12; by = cand_y_q + HALF12; end
            EAST:    begin ax = cand_x_q + HALF12; bx = cand_x_q + HALF12; end
            default: begin ax = cand_x_q - HALF12; bx = cand_x_q - HALF12; end
        endcase
        corner_x = (state_q == REQ1) ? bx : ax;
        corner_y = (state_q == REQ1) ? by : ay;
    end

    tile_index u_tile_index (
        .x    (corner_x),
        .y    (corner_y),
        .addr (corner_addr)
    );

    // Tile port strobes during the two request states; address idles at zero.
    always_comb begin
        tile_req  = (state_q == REQ0) || (state_q == REQ1);
        tile_addr = tile_req ? corner_addr : 13'd0;
        tile_ok   = is_passable(tile_t'(tile_data));
    end

    // Frame tick detect and the update state machine.
    always_comb begin
        state_d  = state_q;
        vs_d     = VGA_VS;
        tick_d   = vs_q & ~VGA_VS;
        keys_d   = keys_q;
        cand_x_d = cand_x_q;
        cand_y_d = cand_y_q;
        pass_a_d = pass_a_q;
        x_d      = x_q;
        y_d      = y_q;
        dir_d    = dir_q;
        moving_d = moving_q;
        done_d   = 1'b0;
`ifdef SPRINT_EN
        sprint_d = sprint_q;
        retry_d  = retry_q;
`endif
        case (state_q)
            IDLE: begin
                if (tick_q) begin
                    if (keys != 4'd0) begin
                        keys_d  = keys;
`ifdef SPRINT_EN
                        sprint_d = sprint;
                        retry_d  = 1'b0;
`endif
                        state_d = CALC;
                    end else begin
                        moving_d = 1'b0;
                        done_d   = 1'b1;
                    end
                end
            end
            CALC: begin
                dir_d    = win_dir;
                cand_x_d = cand_x_c;
                cand_y_d = cand_y_c;
                state_d  = REQ0;
            end
            REQ0:  state_d = WAIT0;
            WAIT0: begin
                pass_a_d = tile_ok;
                state_d  = REQ1;
            end
            REQ1:  state_d = WAIT1;
            WAIT1: begin
                // Position and done load here so they are visible during COMMIT.
                if (pass_a_q && tile_ok) begin
                    x_d      = cand_x_q;
                    y_d      = cand_y_q;
                    moving_d = (cand_x_q != x_q) || (cand_y_q != y_q);
                    done_d   = 1'b1;
                    state_d  = COMMIT;
                end
`ifdef SPRINT_EN
                else if (sprint_q && !retry_q) begin
                    retry_d  = 1'b1;
                    cand_x_d = cand_x_c;
                    cand_y_d = cand_y_c;
                    state_d  = REQ0;
                end
`endif
                else begin
                    moving_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = COMMIT;
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any outstanding tile response.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            vs_q     <= 1'b0;
            tick_q   <= 1'b0;
            keys_q   <= 4'd0;
            cand_x_q <= 12'd0;
            cand_y_q <= 12'd0;
            pass_a_q <= 1'b0;
            x_q      <= 12'(X_INIT);
            y_q      <= 12'(Y_INIT);
            dir_q    <= SOUTH;
            moving_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef SPRINT_EN
            sprint_q <= 1'b0;
            retry_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            vs_q     <= vs_d;
            tick_q   <= tick_d;
            keys_q   <= keys_d;
            cand_x_q <= cand_x_d;
            cand_y_q <= cand_y_d;
            pass_a_q <= pass_a_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dir_q    <= dir_d;
            moving_q <= moving_d;
            done_q   <= done_d;
`ifdef SPRINT_EN
            sprint_q <= sprint_d;
            retry_q  <= retry_d;
`endif
        end
    end

    assign x_pos       = x_q;
    assign y_pos       = y_q;
    assign dir         = dir_q;
    assign moving      = moving_q;
    assign update_done = done_q;

endmodule

// File: tb/tb_player_motion.sv
// Testbench for player_motion: directed scenarios plus randomized frames
// against a behavioural position/collision model and a tile ROM responder.
module tb_player_motion;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        VGA_VS;
    logic [3:0]  keys;
`ifdef SPRINT_EN
    logic        sprint_i;
`endif
    logic        tile_req;
    logic [12:0] tile_addr;
    logic [1:0]  tile_data;
    logic [11:0] x_pos;
    logic [11:0] y_pos;
    logic [1:0]  dir;
    logic        moving;
    logic        update_done;

    always #10 Clk = ~Clk;

    player_motion dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .VGA_VS      (VGA_VS),
        .keys        (keys),
`ifdef SPRINT_EN
        .sprint      (sprint_i),
`endif
        .tile_req    (tile_req),
        .tile_addr   (tile_addr),
        .tile_data   (tile_data),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .dir         (dir),
        .moving      (moving),
        .update_done (update_done)
    );

    logic [1:0] tmap [0:7499];
    int         req_log[$];
    int         exp_addr[$];

    // Tile ROM: answers one cycle after each request and logs requested addresses.
    always @(posedge Clk) begin
        if (tile_req) req_log.push_back(int'(tile_addr));
        tile_data <= (tile_addr < 13'd7500) ? tmap[tile_addr] : 2'b00;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference state
    int mx = 1600, my = 1200, mdir = 1, mmov = 0;

    function automatic int addr_of(input int x, input int y);
        return (y / 32) * 100 + (x / 32);
    endfunction

    function automatic bit ok_tile(input int a);
        return (tmap[a] == 2'b01) || (tmap[a] == 2'b11);
    endfunction

    task automatic fill_map(input logic [1:0] code);
        for (int a = 0; a < 7500; a++) tmap[a] = code;
    endtask

    task automatic model_try(input int d, input int step, output int cx, output int cy, output bit pass);
        int a0, a1;
        cx = mx;
        cy = my;
        case (d)
            0: cy = cy - step;
            1: cy = cy + step;
            2: cx = cx + step;
            default: cx = cx - step;
        endcase
        if (cx < 47) cx = 47;
        if (cx > 3152) cx = 3152;
        if (cy < 47) cy = 47;
        if (cy > 2352) cy = 2352;
        case (d)
            0: begin a0 = addr_of(cx - 15, cy - 15); a1 = addr_of(cx + 15, cy - 15); end
            1: begin a0 = addr_of(cx - 15, cy + 15); a1 = addr_of(cx + 15, cy + 15); end
            2: begin a0 = addr_of(cx + 15, cy - 15); a1 = addr_of(cx + 15, cy + 15); end
            default: begin a0 = addr_of(cx - 15, cy - 15); a1 = addr_of(cx - 15, cy + 15); end
        endcase
        exp_addr.push_back(a0);
        exp_addr.push_back(a1);
        pass = ok_tile(a0) && ok_tile(a1);
    endtask

    task automatic frame(input logic [3:0] k, input bit s);
        int  lat, d, cx, cy, n, m;
        bit  pass, got;
        exp_addr.delete();
        if (k == 4'd0) begin
            lat  = 1;
            mmov = 0;
        end else begin
            d    = k[3] ? 0 : (k[2] ? 1 : (k[1] ? 3 : 2));
            mdir = d;
            model_try(d, s ? 4 : 2, cx, cy, pass);
            lat  = 6;
            if (!pass && s) begin
                model_try(d, 2, cx, cy, pass);
                lat = 10;
            end
            if (pass) begin
                mmov = (cx != mx || cy != my) ? 1 : 0;
                mx   = cx;
                my   = cy;
            end else begin
                mmov = 0;
            end
        end
        @(negedge Clk);
        keys   = k;
`ifdef SPRINT_EN
        sprint_i = s;
`endif
        VGA_VS = 1'b1;
        @(negedge Clk);
        req_log.delete();
        VGA_VS = 1'b0;
        @(posedge Clk);
        got = 0;
        n   = 0;
        while (!got && n < 16) begin
            @(posedge Clk);
            n++;
            #1;
            if (update_done) got = 1;
        end
        chk("latency", got ? n : -1, lat);
        chk("x_pos", int'(x_pos), mx);
        chk("y_pos", int'(y_pos), my);
        chk("dir", int'(dir), mdir);
        chk("moving", int'(moving), mmov);
        chk("req_count", req_log.size(), exp_addr.size());
        m = (req_log.size() < exp_addr.size()) ? req_log.size() : exp_addr.size();
        for (int i = 0; i < m; i++) chk("tile_addr", req_log[i], exp_addr[i]);
        @(posedge Clk);
        #1;
        chk("done_width", int'(update_done), 0);
        @(negedge Clk);
        VGA_VS = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  cnt;
        bit  s;
        Reset_n = 1'b0;
        VGA_VS  = 1'b1;
        keys    = 4'd0;
`ifdef SPRINT_EN
        sprint_i = 1'b0;
`endif
        fill_map(2'b01);
        repeat (3) @(negedge Clk);
        chk("rst_x", int'(x_pos), 1600);
        chk("rst_y", int'(y_pos), 1200);
        chk("rst_dir", int'(dir), 1);
        chk("rst_moving", int'(moving), 0);
        chk("rst_done", int'(update_done), 0);
        chk("rst_req", int'(tile_req), 0);
        chk("rst_addr", int'(tile_addr), 0);
        Reset_n = 1'b1;
        repeat (3) @(negedge Clk);

        // No keys: immediate done, nothing changes
        frame(4'b0000, 0);

        // Right over grass, three frames
        frame(4'b0001, 0);
        chk("first_addr", (req_log.size() > 0) ? req_log[0] : -1, 3750);
        frame(4'b0001, 0);
        frame(4'b0001, 0);
        chk("right3_x", int'(x_pos), 1606);
        chk("right3_dir", int'(dir), 2);

        // Several keys at once: only up wins
        frame(4'b1011, 0);
        chk("multi_y", int'(y_pos), 1198);
        chk("multi_x", int'(x_pos), 1606);

        // Left blocked by water on corner B
        tmap[addr_of(1606 - 2 - 15, 1198 + 15)] = 2'b10;
        frame(4'b0010, 0);
        chk("water_x", int'(x_pos), 1606);
        chk("water_mov", int'(moving), 0);
        chk("water_dir", int'(dir), 3);
        fill_map(2'b01);

        // Walk up to the top clamp
        while (my > 48) frame(4'b1000, 0);
        chk("pre_clamp_y", int'(y_pos), 48);
        frame(4'b1000, 0);
        chk("clamp_y", int'(y_pos), 47);
        chk("clamp_mov", int'(moving), 1);
        frame(4'b1000, 0);
        chk("clamp_hold_y", int'(y_pos), 47);
        chk("clamp_hold_mov", int'(moving), 0);
        chk("clamp_hold_dir", int'(dir), 0);

        // Randomized map and keys
        for (int a = 0; a < 7500; a++)
            tmap[a] = ($urandom_range(0, 9) < 8) ? (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11)
                                                 : (($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10);
        for (int f = 0; f < 300; f++) begin
            s = 1'b0;
`ifdef SPRINT_EN
            s = ($urandom_range(0, 1) == 1);
`endif
            frame(4'($urandom_range(0, 15)), s);
        end

        // Reset while waiting on the first tile response
        fill_map(2'b01);
        @(negedge Clk);
        keys   = 4'b0001;
        VGA_VS = 1'b1;
        @(negedge Clk);
        VGA_VS = 1'b0;
        @(posedge Clk);
        repeat (3) @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        #1;
        chk("mid_rst_x", int'(x_pos), 1600);
        chk("mid_rst_y", int'(y_pos), 1200);
        chk("mid_rst_dir", int'(dir), 1);
        chk("mid_rst_mov", int'(moving), 0);
        chk("mid_rst_req", int'(tile_req), 0);
        chk("mid_rst_addr", int'(tile_addr), 0);
        mx = 1600; my = 1200; mdir = 1; mmov = 0;
        @(negedge Clk);
        VGA_VS = 1'b1;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(posedge Clk);
            #1;
            if (update_done) cnt++;
        end
        chk("stray_done", cnt, 0);
        frame(4'b0001, 0);
        chk("post_rst_x", int'(x_pos), 1602);

`ifdef SPRINT_EN
        // Sprint blocked at x+4, retry at x+2 succeeds
        repeat (6) frame(4'b0001, 0);
        chk("pre_sprint_x", int'(x_pos), 1614);
        tmap[addr_of(1614 + 4 + 15, 1200)] = 2'b10;
        frame(4'b0001, 1);
        chk("sprint_x", int'(x_pos), 1616);
        chk("sprint_mov", int'(moving), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
